// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, descriptor type and field widths for the SPI transaction arbiter
package spi_pkg;
  localparam int MODE_W = 2;
  localparam int CMD_W  = 6;
  localparam int SEND_W = 10;
  localparam int RESP_W = 6;
  localparam int RECV_W = 10;
  localparam int DESC_W = MODE_W + 1 + CMD_W + SEND_W + RESP_W + RECV_W;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_BUSY,
    S_DONE
  } state_t;
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              clk_ss;
    logic [CMD_W-1:0]  cmd;
    logic [SEND_W-1:0] send;
    logic [RESP_W-1:0] resp;
    logic [RECV_W-1:0] recv;
  } desc_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after i_ptr with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic          w_hit;
  logic [IW-1:0] w_j;
  // walk ptr+1 .. ptr+N modulo N and keep the first requester found
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!w_hit && i_req[w_j]) begin
        w_hit      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI master between N requesters
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int N          = 4,
  parameter int SETTLE_CYC = 256,
  parameter int LAUNCH_TO  = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [2*N-1:0]      req_mode,
  input  logic [N-1:0]        req_clk_ss,
  input  logic [CMD_W*N-1:0]  req_cmd_len,
  input  logic [SEND_W*N-1:0] req_send_len,
  input  logic [RESP_W*N-1:0] req_resp_len,
  input  logic [RECV_W*N-1:0] req_recv_len,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        done,
  output logic [N-1:0]        err,
  output logic                resp_ok,
  output logic                spi_start,
  output logic [MODE_W-1:0]   spi_mode,
  output logic                spi_clk_ss,
  output logic [CMD_W-1:0]    spi_cmd_len,
  output logic [SEND_W-1:0]   spi_send_len,
  output logic [RESP_W-1:0]   spi_resp_len,
  output logic [RECV_W-1:0]   spi_recv_len,
  input  logic                busy_spi,
  input  logic                valid_response,
  input  logic                valid_spi
);
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(LAUNCH_TO + 1);
  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [SW-1:0] r_set_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_busy_q;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  desc_t         w_desc [N];
  desc_t         w_sel;
  for (genvar i = 0; i < N; i++) begin : g_desc
    assign w_desc[i] = '{
      mode:   req_mode[MODE_W*i +: MODE_W],
      clk_ss: req_clk_ss[i],
      cmd:    req_cmd_len[CMD_W*i +: CMD_W],
      send:   req_send_len[SEND_W*i +: SEND_W],
      resp:   req_resp_len[RESP_W*i +: RESP_W],
      recv:   req_recv_len[RECV_W*i +: RECV_W]
    };
  end
  assign w_sel = w_desc[w_idx];
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  // transaction FSM; spi_* config is only loaded on the grant so it stays frozen mid-transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= IW'(N - 1);
      r_set_cnt    <= '0;
      r_to_cnt     <= '0;
      r_busy_q     <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      resp_ok      <= 1'b0;
      spi_start    <= 1'b0;
      spi_mode     <= '0;
      spi_clk_ss   <= 1'b0;
      spi_cmd_len  <= '0;
      spi_send_len <= '0;
      spi_resp_len <= '0;
      spi_recv_len <= '0;
    end else begin
      done     <= '0;
      err      <= '0;
      r_busy_q <= busy_spi;
      case (r_state)
        S_IDLE: if (|req) begin
          spi_mode     <= w_sel.mode;
          spi_clk_ss   <= w_sel.clk_ss;
          spi_cmd_len  <= w_sel.cmd;
          spi_send_len <= w_sel.send;
          spi_resp_len <= w_sel.resp;
          spi_recv_len <= w_sel.recv;
          gnt          <= w_gnt;
          r_ptr        <= w_idx;
          r_set_cnt    <= '0;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: if (!req[r_ptr]) begin
          gnt     <= '0;
          r_state <= S_IDLE;
        end else if (r_set_cnt == SW'(SETTLE_CYC - 1)) begin
          spi_start <= 1'b1;
          r_to_cnt  <= '0;
          r_state   <= S_LAUNCH;
        end else begin
          r_set_cnt <= r_set_cnt + 1'b1;
        end
        S_LAUNCH: if (busy_spi) begin
          spi_start <= 1'b0;
          r_state   <= S_BUSY;
        end else if (r_to_cnt == TW'(LAUNCH_TO - 1)) begin
          spi_start <= 1'b0;
          err       <= N'(1) << r_ptr;
          gnt       <= '0;
          r_state   <= S_IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        S_BUSY: if (r_busy_q && !busy_spi) begin
          resp_ok <= valid_response;
          gnt     <= '0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= N'(1) << r_ptr;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  a_valid_in_txn: assert property (@(posedge clk) disable iff (!rst_n)
    valid_spi |-> (r_state == S_BUSY || r_state == S_DONE));
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: scoreboard bench, stimulus pushes expected grant/done/err events, monitor pops them
module tb_spi_txn_arbiter;
  import spi_pkg::*;
  localparam int N  = 4;
  localparam int SC = 256;
  localparam int LT = 16;
  localparam logic [1:0] K_GNT = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;
  typedef struct {
    logic [1:0] kind;
    logic [3:0] oh;
    logic       ok;
    desc_t      cfg;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] req_mode;
  logic [N-1:0] req_clk_ss;
  logic [CMD_W*N-1:0] req_cmd_len;
  logic [SEND_W*N-1:0] req_send_len;
  logic [RESP_W*N-1:0] req_resp_len;
  logic [RECV_W*N-1:0] req_recv_len;
  logic [N-1:0] gnt, done, err;
  logic resp_ok, spi_start, spi_clk_ss;
  logic [MODE_W-1:0] spi_mode;
  logic [CMD_W-1:0] spi_cmd_len;
  logic [SEND_W-1:0] spi_send_len;
  logic [RESP_W-1:0] spi_resp_len;
  logic [RECV_W-1:0] spi_recv_len;
  logic busy_spi = 1'b0, valid_response = 1'b0, valid_spi = 1'b0;
  desc_t d [N];
  desc_t cur, snap;
  exp_t q [$];
  int n_vec = 0, n_bad = 0, cyc = 0, n_start = 0;
  int g_cyc = 0, s_cyc = 0, fall_cyc = 0;
  logic m_en = 1'b0, m_ok = 1'b0;
  spi_txn_arbiter #(.N(N), .SETTLE_CYC(SC), .LAUNCH_TO(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode), .req_clk_ss(req_clk_ss),
    .req_cmd_len(req_cmd_len), .req_send_len(req_send_len), .req_resp_len(req_resp_len),
    .req_recv_len(req_recv_len), .gnt(gnt), .done(done), .err(err), .resp_ok(resp_ok),
    .spi_start(spi_start), .spi_mode(spi_mode), .spi_clk_ss(spi_clk_ss),
    .spi_cmd_len(spi_cmd_len), .spi_send_len(spi_send_len), .spi_resp_len(spi_resp_len),
    .spi_recv_len(spi_recv_len), .busy_spi(busy_spi), .valid_response(valid_response),
    .valid_spi(valid_spi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cur = {spi_mode, spi_clk_ss, spi_cmd_len, spi_send_len, spi_resp_len, spi_recv_len};
  always_comb begin
    req_mode = '0; req_clk_ss = '0; req_cmd_len = '0;
    req_send_len = '0; req_resp_len = '0; req_recv_len = '0;
    for (int i = 0; i < N; i++) begin
      req_mode[2*i +: 2] = d[i].mode;
      req_clk_ss[i] = d[i].clk_ss;
      req_cmd_len[CMD_W*i +: CMD_W] = d[i].cmd;
      req_send_len[SEND_W*i +: SEND_W] = d[i].send;
      req_resp_len[RESP_W*i +: RESP_W] = d[i].resp;
      req_recv_len[RECV_W*i +: RECV_W] = d[i].recv;
    end
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push(logic [1:0] k, logic [3:0] oh, logic ok, desc_t c);
    exp_t e;
    e = '{kind: k, oh: oh, ok: ok, cfg: c};
    q.push_back(e);
  endtask
  task automatic take(string nm, logic [1:0] k, logic [3:0] oh, output exp_t e);
    e = '{kind: 2'd3, oh: 4'd0, ok: 1'b0, cfg: '0};
    if (q.size() == 0) chk({nm, "_unexpected"}, {58'd0, k, oh}, 64'd0);
    else begin
      e = q.pop_front();
      chk(nm, {k, oh}, {e.kind, e.oh});
    end
  endtask
  function automatic logic hit(int w);
    return w == 0 ? (|done || |err) : w == 1 ? |gnt : w == 2 ? spi_start : busy_spi;
  endfunction
  task automatic wait_on(string nm, int w, int max);
    int c = 0;
    do begin @(negedge clk); c++; end while (!hit(w) && c < max);
    chk({nm, "_wait"}, {63'd0, hit(w)}, 64'd1);
  endtask
  // master model: answers spi_start with a short busy burst and a response flag
  initial forever begin
    @(negedge clk);
    if (m_en && spi_start) begin
      repeat (2) @(posedge clk);
      #1 busy_spi = 1'b1;
      repeat (6) @(posedge clk);
      #1 valid_spi = 1'b1; valid_response = m_ok;
      @(posedge clk);
      #1 busy_spi = 1'b0; valid_spi = 1'b0;
    end
  end
  // monitor: pops the scoreboard on each grant/done/err and checks timing
  initial begin
    exp_t e;
    logic [N-1:0] pg = '0;
    logic ps = 1'b0, pb = 1'b0, drop_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (drop_pend) begin chk("start_drop_on_busy", {63'd0, spi_start}, 64'd0); drop_pend = 1'b0; end
        if (!pb && busy_spi) drop_pend = 1'b1;
        if (pb && !busy_spi) fall_cyc = cyc;
        if (!ps && spi_start) begin n_start++; chk("settle_len", cyc - g_cyc, SC); s_cyc = cyc; end
        if (pg == '0 && gnt != '0) begin
          take("grant", K_GNT, gnt, e);
          chk("grant_cfg", {29'd0, cur}, {29'd0, e.cfg});
          g_cyc = cyc; snap = cur;
        end
        if (err != '0) begin
          take("err", K_ERR, err, e);
          chk("launch_timeout_len", cyc - s_cyc, LT);
        end
        if (done != '0) begin
          take("done", K_DONE, done, e);
          chk("resp_ok", {63'd0, resp_ok}, {63'd0, e.ok});
          chk("done_latency", cyc - fall_cyc, 2);
          chk("cfg_stable", {29'd0, cur}, {29'd0, snap});
        end
      end
      pg = gnt; ps = spi_start; pb = busy_spi;
    end
  end
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ok_tab [5];
    int idx_tab [5];
    int n0;
    desc_t old1;
    ok_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    idx_tab = '{0, 1, 2, 3, 0};
    d[0] = '{mode: 2'b00, clk_ss: 1'b1, cmd: 6'd6,  send: 10'd0,    resp: 6'd1,  recv: 10'd0};
    d[1] = '{mode: 2'b01, clk_ss: 1'b0, cmd: 6'd3,  send: 10'h012,  resp: 6'd2,  recv: 10'h020};
    d[2] = '{mode: 2'b10, clk_ss: 1'b1, cmd: 6'd63, send: 10'h3ff,  resp: 6'd63, recv: 10'h3ff};
    d[3] = '{mode: 2'b11, clk_ss: 1'b0, cmd: 6'd1,  send: 10'd1,    resp: 6'd0,  recv: 10'h3fe};
    repeat (3) @(negedge clk);
    chk("rst_gnt", {60'd0, gnt}, 64'd0);
    chk("rst_done_err", {56'd0, done, err}, 64'd0);
    chk("rst_start_resp", {62'd0, spi_start, resp_ok}, 64'd0);
    chk("rst_cfg", {29'd0, cur}, 64'd0);
    rst_n = 1'b1;
    // round robin: all four requesting, order 0,1,2,3,0
    m_en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      push(K_GNT, 4'b0001 << idx_tab[t], 1'b0, d[idx_tab[t]]);
      push(K_DONE, 4'b0001 << idx_tab[t], ok_tab[t], d[idx_tab[t]]);
    end
    m_ok = ok_tab[0];
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_on("rr_done", 0, 1000);
      if (t < 4) m_ok = ok_tab[t + 1];
    end
    req = 4'b0000;
    // single request from requester 0
    m_ok = 1'b1;
    push(K_GNT, 4'b0001, 1'b0, d[0]);
    push(K_DONE, 4'b0001, 1'b1, d[0]);
    req = 4'b0001;
    wait_on("single_done", 0, 1000);
    req = 4'b0000;
    // cancel in settle: req[2] drops, requester 3 is served next
    n0 = n_start;
    push(K_GNT, 4'b0100, 1'b0, d[2]);
    push(K_GNT, 4'b1000, 1'b0, d[3]);
    push(K_DONE, 4'b1000, 1'b1, d[3]);
    req = 4'b1100;
    wait_on("cancel_gnt", 1, 20);
    repeat (10) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("cancel_gnt_clear", {60'd0, gnt}, 64'd0);
    wait_on("cancel_done", 0, 1000);
    req = 4'b0000;
    chk("cancel_no_start", n_start, n0 + 1);
    // launch timeout: master never raises busy
    m_en = 1'b0;
    push(K_GNT, 4'b0010, 1'b0, d[1]);
    push(K_ERR, 4'b0010, 1'b0, d[1]);
    req = 4'b0010;
    wait_on("timeout_err", 0, 1000);
    req = 4'b0000;
    @(negedge clk);
    chk("timeout_start_low", {63'd0, spi_start}, 64'd0);
    // config stability: requester 1 changes recv_len while busy
    m_en = 1'b1;
    m_ok = 1'b1;
    old1 = d[1];
    push(K_GNT, 4'b0010, 1'b0, old1);
    push(K_DONE, 4'b0010, 1'b1, old1);
    req = 4'b0010;
    wait_on("stab_busy", 3, 1000);
    d[1].recv = 10'h155;
    repeat (2) @(negedge clk);
    chk("stab_recv_len", {54'd0, spi_recv_len}, {54'd0, old1.recv});
    wait_on("stab_done", 0, 1000);
    req = 4'b0000;
    @(negedge clk);
    push(K_GNT, 4'b0010, 1'b0, d[1]);
    push(K_DONE, 4'b0010, 1'b1, d[1]);
    req = 4'b0010;
    wait_on("stab_done2", 0, 1000);
    req = 4'b0000;
    // reset while busy: everything returns to reset values, requester 0 wins afterwards
    m_en = 1'b0;
    push(K_GNT, 4'b0100, 1'b0, d[2]);
    req = 4'b0100;
    wait_on("rstb_start", 2, 1000);
    @(posedge clk);
    #1 busy_spi = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstb_gnt", {60'd0, gnt}, 64'd0);
    chk("rstb_start_resp", {62'd0, spi_start, resp_ok}, 64'd0);
    chk("rstb_cfg", {29'd0, cur}, 64'd0);
    busy_spi = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    push(K_GNT, 4'b0001, 1'b0, d[0]);
    rst_n = 1'b1;
    wait_on("rstb_regrant", 1, 20);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("rstb_no_pulses", {56'd0, done, err}, 64'd0);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
